// File: rtl/dram_bank_ctrl.sv
// dram_bank_ctrl - per-bank DDR2 command sequencer.
//
// Takes one decoded request into a single-entry holding register and walks
// the bank through ACT / RD / WR / PRE / REF, offering each command to the
// shared scheduler as a req/gnt pair. DRAM timing is enforced with local
// saturating down-counters.
//
// Ports:
//   clk, rst                  controller clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready = holding register empty)
//   req_id/ra/ca/len/wr       request fields
//   t_rcd/t_rp/t_ras/t_rfc    timing parameters in controller cycles
//   t_rtp/t_wtp
//   ref_due                   level refresh request; ref_done pulses on REF grant
//   sched_ra/ca/id/len        held request fields for the offered command
//   *_req / *_gnt             command offers and grants (act, rd, wr, pre, ref)
//
// Build option: define BK_AUTO_PRE_EN for a closed-page policy (precharge
// after a column command unless the next held request hits the open row).
// Default is open-page.
module dram_bank_ctrl #(
    parameter int ID_WIDTH = 4,
    parameter int RA_WIDTH = 14,
    parameter int CA_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_WIDTH-1:0] req_id,
    input  logic [RA_WIDTH-1:0] req_ra,
    input  logic [CA_WIDTH-1:0] req_ca,
    input  logic [3:0]          req_len,
    input  logic                req_wr,
    input  logic [3:0]          t_rcd,
    input  logic [3:0]          t_rp,
    input  logic [4:0]          t_ras,
    input  logic [7:0]          t_rfc,
    input  logic [3:0]          t_rtp,
    input  logic [3:0]          t_wtp,
    input  logic                ref_due,
    output logic                ref_done,
    output logic [RA_WIDTH-1:0] sched_ra,
    output logic [CA_WIDTH-1:0] sched_ca,
    output logic [ID_WIDTH-1:0] sched_id,
    output logic [3:0]          sched_len,
    output logic                act_req,
    output logic                rd_req,
    output logic                wr_req,
    output logic                pre_req,
    output logic                ref_req,
    input  logic                act_gnt,
    input  logic                rd_gnt,
    input  logic                wr_gnt,
    input  logic                pre_gnt,
    input  logic                ref_gnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PRECHARGE, S_REFRESH} state_t;
    typedef enum logic [2:0] {C_NONE, C_ACT, C_RD, C_WR, C_PRE, C_REF} cmd_t;

    state_t state, state_n;
    cmd_t   cur, cur_n, offer;

    logic                held;
    logic [ID_WIDTH-1:0] h_id;
    logic [RA_WIDTH-1:0] h_ra;
    logic [CA_WIDTH-1:0] h_ca;
    logic [3:0]          h_len;
    logic                h_wr;
    logic [RA_WIDTH-1:0] open_row;

    // Counters hold (cycles remaining - 1): loading T-1 at the grant edge makes
    // the value reach 0 exactly in cycle N+T, so "met" is simply == 0.
    logic [3:0] cnt_rcd, cnt_rp, cnt_rtp;
    logic [4:0] cnt_ras;
    logic [7:0] cnt_rfc;
    logic [3:0] rtp_dec, rtp_new;

    logic rcd_ok, pre_ok, open_ok, row_hit;
    logic act_g, rd_g, wr_g, pre_g, ref_g, any_g;

`ifdef BK_AUTO_PRE_EN
    logic col_done;
`endif

    function automatic logic [3:0] ld4(input logic [3:0] t);
        return (t == 4'd0) ? 4'd0 : t - 4'd1;
    endfunction

    function automatic logic [4:0] ld5(input logic [4:0] t);
        return (t == 5'd0) ? 5'd0 : t - 5'd1;
    endfunction

    function automatic logic [7:0] ld8(input logic [7:0] t);
        return (t == 8'd0) ? 8'd0 : t - 8'd1;
    endfunction

    assign rcd_ok  = (cnt_rcd == '0);
    assign pre_ok  = (cnt_ras == '0) && (cnt_rtp == '0);
    assign open_ok = (cnt_rp == '0) && (cnt_rfc == '0);
    assign row_hit = (h_ra == open_row);

    // Offer selection. Once a command has been offered it is latched in cur
    // and re-offered unchanged until granted, so later changes of ref_due or
    // the holding register cannot withdraw or swap a pending offer.
    // PRECHARGE/REFRESH act as closed-bank states as soon as their timers are
    // met, so ACT/REF can be offered in the first legal cycle.
    always_comb begin
        offer = C_NONE;
        if (cur != C_NONE) begin
            offer = cur;
        end else begin
            case (state)
                S_ACTIVE: begin
                    if (ref_due) begin
                        if (pre_ok) offer = C_PRE;
                    end else if (held && row_hit) begin
                        if (rcd_ok) offer = h_wr ? C_WR : C_RD;
                    end else if (held) begin
                        if (pre_ok) offer = C_PRE;
                    end
`ifdef BK_AUTO_PRE_EN
                    else if (col_done) begin
                        if (pre_ok) offer = C_PRE;
                    end
`endif
                end
                default: begin
                    if (open_ok) begin
                        if (ref_due)   offer = C_REF;
                        else if (held) offer = C_ACT;
                    end
                end
            endcase
        end
    end

    assign act_req = (offer == C_ACT);
    assign rd_req  = (offer == C_RD);
    assign wr_req  = (offer == C_WR);
    assign pre_req = (offer == C_PRE);
    assign ref_req = (offer == C_REF);

    assign act_g = act_req & act_gnt;
    assign rd_g  = rd_req  & rd_gnt;
    assign wr_g  = wr_req  & wr_gnt;
    assign pre_g = pre_req & pre_gnt;
    assign ref_g = ref_req & ref_gnt;
    assign any_g = act_g | rd_g | wr_g | pre_g | ref_g;

    assign ref_done  = ref_g;
    assign req_ready = ~held;
    assign sched_ra  = h_ra;
    assign sched_ca  = h_ca;
    assign sched_id  = h_id;
    assign sched_len = h_len;

    always_comb begin
        state_n = state;
        cur_n   = any_g ? C_NONE : offer;
        case (state)
            S_ACTIVE: if (pre_g) state_n = S_PRECHARGE;
            default: begin
                if (act_g)                          state_n = S_ACTIVE;
                else if (ref_g)                     state_n = S_REFRESH;
                else if (state != S_IDLE && open_ok) state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rtp_dec = (cnt_rtp != '0) ? cnt_rtp - 4'd1 : '0;
        rtp_new = rd_g ? ld4(t_rtp) : ld4(t_wtp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur      <= C_NONE;
            held     <= 1'b0;
            h_id     <= '0;
            h_ra     <= '0;
            h_ca     <= '0;
            h_len    <= '0;
            h_wr     <= 1'b0;
            open_row <= '0;
            cnt_rcd  <= '0;
            cnt_rp   <= '0;
            cnt_rtp  <= '0;
            cnt_ras  <= '0;
            cnt_rfc  <= '0;
        end else begin
            state <= state_n;
            cur   <= cur_n;

            if (req_valid && !held) begin
                held  <= 1'b1;
                h_id  <= req_id;
                h_ra  <= req_ra;
                h_ca  <= req_ca;
                h_len <= req_len;
                h_wr  <= req_wr;
            end else if (rd_g || wr_g) begin
                held <= 1'b0;
            end

            if (act_g) open_row <= h_ra;

            if (act_g) begin
                cnt_rcd <= ld4(t_rcd);
                cnt_ras <= ld5(t_ras);
            end else begin
                cnt_rcd <= (cnt_rcd != '0) ? cnt_rcd - 4'd1 : '0;
                cnt_ras <= (cnt_ras != '0) ? cnt_ras - 5'd1 : '0;
            end

            if (pre_g) cnt_rp <= ld4(t_rp);
            else       cnt_rp <= (cnt_rp != '0) ? cnt_rp - 4'd1 : '0;

            if (ref_g) cnt_rfc <= ld8(t_rfc);
            else       cnt_rfc <= (cnt_rfc != '0) ? cnt_rfc - 8'd1 : '0;

            // RD->PRE and WR->PRE share a counter; keep whichever ends later.
            if (rd_g || wr_g) cnt_rtp <= (rtp_new > rtp_dec) ? rtp_new : rtp_dec;
            else              cnt_rtp <= rtp_dec;
        end
    end

`ifdef BK_AUTO_PRE_EN
    always_ff @(posedge clk) begin
        if (rst)                col_done <= 1'b0;
        else if (act_g)         col_done <= 1'b0;
        else if (rd_g || wr_g)  col_done <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dram_bank_ctrl.sv
module tb_dram_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [13:0] req_ra;
    logic [9:0]  req_ca;
    logic [3:0]  req_len;
    logic        req_wr;
    logic [3:0]  t_rcd, t_rp, t_rtp, t_wtp;
    logic [4:0]  t_ras;
    logic [7:0]  t_rfc;
    logic        ref_due;
    logic        ref_done;
    logic [13:0] sched_ra;
    logic [9:0]  sched_ca;
    logic [3:0]  sched_id;
    logic [3:0]  sched_len;
    logic        act_req, rd_req, wr_req, pre_req, ref_req;
    logic        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;

    logic stall_rd = 1'b0;
    logic spur     = 1'b0;

    int cyc        = 0;
    int n_checks   = 0;
    int n_pass     = 0;
    int onehot_err = 0;

    dram_bank_ctrl #(.ID_WIDTH(4), .RA_WIDTH(14), .CA_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_ra(req_ra), .req_ca(req_ca),
        .req_len(req_len), .req_wr(req_wr),
        .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc),
        .t_rtp(t_rtp), .t_wtp(t_wtp),
        .ref_due(ref_due), .ref_done(ref_done),
        .sched_ra(sched_ra), .sched_ca(sched_ca),
        .sched_id(sched_id), .sched_len(sched_len),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
        .pre_req(pre_req), .ref_req(ref_req),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .pre_gnt(pre_gnt), .ref_gnt(ref_gnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scheduler model: grant every offer immediately unless stalled;
    // spur drives every grant line regardless of offers.
    assign act_gnt = act_req | spur;
    assign rd_gnt  = (rd_req & ~stall_rd) | spur;
    assign wr_gnt  = wr_req | spur;
    assign pre_gnt = pre_req | spur;
    assign ref_gnt = ref_req | spur;

    always @(negedge clk)
        if (!rst && ($countones({act_req, rd_req, wr_req, pre_req, ref_req}) > 1))
            onehot_err <= onehot_err + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return act_req;
            1: return rd_req;
            2: return wr_req;
            3: return pre_req;
            4: return ref_req;
            5: return req_ready;
            default: return 1'b0;
        endcase
    endfunction

    // Poll at negedges (current one first) until the selected signal is high.
    task automatic wait_sig(input int s, input string tag, output int at);
        logic found;
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < 60; i++) begin
            if (sig(s)) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_seen"}, found, 1);
    endtask

    // Present a request at negedges until accepted; returns at the negedge
    // after the accepting edge with req_valid low.
    task automatic send_req(input logic [3:0] id, input logic [13:0] ra, input logic [9:0] ca,
                            input logic [3:0] len, input logic wr, output int acc);
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            req_valid = 1'b1;
            req_id    = id;
            req_ra    = ra;
            req_ca    = ca;
            req_len   = len;
            req_wr    = wr;
            if (req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (acc < 0) check("accept_timeout", req_ready, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    int acc, a1, r1, r2, p, a2, w2, p4, f, a4, r4, s, a5, a6, w6, p6, x;
    int bad;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_id = '0; req_ra = '0; req_ca = '0;
        req_len = '0; req_wr = 1'b0; ref_due = 1'b0;
        t_rcd = 4'd3; t_rp = 4'd3; t_ras = 5'd8; t_rfc = 8'd20; t_rtp = 4'd2; t_wtp = 4'd4;

        // Reset state
        do_reset();
        check("rst_ready", req_ready, 1);
        check("rst_reqs", {act_req, rd_req, wr_req, pre_req, ref_req, ref_done}, 6'b0);
        check("rst_sched", {sched_ra, sched_ca, sched_id, sched_len}, 32'h0);

        // 1: read to closed bank
        send_req(4'd5, 14'h12, 10'h40, 4'd3, 1'b0, acc);
        wait_sig(0, "t1_act", a1);
        check("t1_act_at", a1, acc + 1);
        check("t1_act_ra", sched_ra, 14'h12);
        wait_sig(1, "t1_rd", r1);
        check("t1_rd_at", r1, a1 + 3);
        check("t1_rd_ca", sched_ca, 10'h40);
        check("t1_rd_id_len", {sched_id, sched_len}, 8'h53);
        check("t1_ready_low", req_ready, 0);
        wait_sig(5, "t1_ready", x);
        check("t1_ready_at", x, r1 + 1);

        // 2: back-to-back hit, then miss
        send_req(4'd6, 14'h12, 10'h41, 4'd1, 1'b0, acc);
        wait_sig(1, "t2_rd", r2);
        check("t2_hit_rd_at", r2, r1 + 2);
        send_req(4'd7, 14'h13, 10'h07, 4'd2, 1'b1, acc);
        wait_sig(3, "t2_pre", p);
        check("t2_pre_at", p, imax(a1 + 8, r2 + 2));
        wait_sig(0, "t2_act", a2);
        check("t2_act_at", a2, p + 3);
        check("t2_act_ra", sched_ra, 14'h13);
        wait_sig(2, "t2_wr", w2);
        check("t2_wr_at", w2, a2 + 3);

        // 4: refresh request with a held row hit
        wait_sig(5, "t4_ready", x);
        ref_due = 1'b1;
        send_req(4'hB, 14'h13, 10'h22, 4'd4, 1'b0, acc);
        check("t4_col_blocked", {rd_req, pre_req}, 2'b00);
        wait_sig(3, "t4_pre", p4);
        check("t4_pre_at", p4, imax(a2 + 8, w2 + 4));
        wait_sig(4, "t4_ref", f);
        check("t4_ref_at", f, p4 + 3);
        check("t4_ref_done", ref_done, 1);
        @(negedge clk);
        check("t4_ref_done_pulse", ref_done, 0);
        ref_due = 1'b0;
        wait_sig(0, "t4_act", a4);
        check("t4_act_at", a4, f + 20);
        wait_sig(1, "t4_rd", r4);
        check("t4_rd_at", r4, a4 + 3);
        check("t4_rd_ca", sched_ca, 10'h22);

        // 3: scheduler stall on a held read
        wait_sig(5, "t3_ready", x);
        stall_rd = 1'b1;
        send_req(4'd9, 14'h13, 10'h155, 4'hA, 1'b0, acc);
        wait_sig(1, "t3_rd", s);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rd_req || sched_ca != 10'h155 || sched_id != 4'd9 || sched_len != 4'hA ||
                act_req || wr_req || pre_req || ref_req)
                bad++;
            @(negedge clk);
        end
        check("t3_stable", bad, 0);
        stall_rd = 1'b0;
        check("t3_rd_after_stall", rd_req, 1);
        wait_sig(5, "t3_ready", x);
        check("t3_ready_at", x, s + 6);

        // 5: spurious grants, then reset right after ACT
        do_reset();
        spur = 1'b1;
        check("t5_spur_ref_done", ref_done, 0);
        @(negedge clk);
        spur = 1'b0;
        check("t5_spur_ready", req_ready, 1);
        send_req(4'hC, 14'h30, 10'h11, 4'd5, 1'b1, acc);
        wait_sig(0, "t5_act", a5);
        check("t5_act_at", a5, acc + 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_reqs", {act_req, rd_req, wr_req, pre_req, ref_req}, 5'b0);
        check("t5_rst_ready", req_ready, 1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (act_req || rd_req || wr_req || pre_req || ref_req) bad++;
            @(negedge clk);
        end
        check("t5_no_replay", bad, 0);

        // 6: single write, t_rcd = 0 treated as 1, page policy
        t_rcd = 4'd0;
        t_ras = 5'd2;
        do_reset();
        send_req(4'hD, 14'h20, 10'h10, 4'd2, 1'b1, acc);
        wait_sig(0, "t6_act", a6);
        wait_sig(2, "t6_wr", w6);
        check("t6_wr_at", w6, a6 + 1);
`ifdef BK_AUTO_PRE_EN
        wait_sig(3, "t6_pre", p6);
        check("t6_pre_at", p6, w6 + 4);
        send_req(4'hE, 14'h20, 10'h12, 4'd1, 1'b0, acc);
        wait_sig(0, "t6_reopen", x);
        check("t6_reopen_at", x, p6 + 3);
`else
        p6  = 0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (pre_req) bad++;
            @(negedge clk);
        end
        check("t6_open_page", bad, p6);
        send_req(4'hE, 14'h20, 10'h12, 4'd1, 1'b0, acc);
        wait_sig(1, "t6_hit", x);
        check("t6_hit_at", x, acc + 1);
`endif

        check("onehot", onehot_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_bank_ctrl.md
# dram_bank_ctrl

Per-bank command sequencer for the DDR2 controller. It accepts one decoded request at a time on the bank request handshake and runs an ACT / RD / WR / PRE / REF state machine. Every DRAM timing constraint is enforced with local down-counters. Commands are offered to the shared command scheduler as req/gnt pairs. One instance per bank sits between the request dispatcher, which is upstream, and the command scheduler/DFI arbiter, which is downstream.

## Interface
- ID_WIDTH, 4, request ID width
- RA_WIDTH, 14, row address width
- CA_WIDTH, 10, column address width
- clk  in  1  controller clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  holding register empty
- req_id  in  ID_WIDTH  request ID
- req_ra / req_ca  in  RA_WIDTH / CA_WIDTH  row / column
- req_len  in  4  burst length code
- req_wr  in  1  1 = write, 0 = read
- t_rcd, t_rp  in  4 each  ACT→col, PRE→ACT/REF
- t_ras  in  5  ACT→PRE
- t_rfc  in  8  REF→ACT
- t_rtp, t_wtp  in  4 each  RD→PRE, WR→PRE
- ref_due  in  1  level request from the refresh timer
- ref_done  out  1  one-cycle pulse when REF is granted
- sched_ra / sched_ca  out  RA_WIDTH / CA_WIDTH  address for the offered command
- sched_id / sched_len  out  ID_WIDTH / 4  held request's ID and len
- act_req, rd_req, wr_req, pre_req, ref_req  out  1 each  command offers
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  in  1 each  grants

## Operation
- Holding register (one entry):
  - Loads on req_valid & req_ready.
  - req_ready = ~held.
  - Cleared on rd_gnt or wr_gnt; req_ready rises the following cycle.
- States and transitions:
  - IDLE, bank closed:
    - ref_due → ref_req.
    - Otherwise, if held → act_req with sched_ra = held ra.
    - On act_gnt → ACTIVE and open_row is latched.
    - On ref_gnt → REFRESH.
  - ACTIVE:
    - If ref_due → pre_req. Column commands are blocked while ref_due is high; the held request is retained.
    - Held, row hit (ra == open_row) → rd_req or wr_req per req_wr, with sched_ca = held ca.
    - Held, row miss → pre_req.
    - On pre_gnt → PRECHARGE.
  - PRECHARGE: when the tRP counter reaches 0 → IDLE.
  - REFRESH: when the tRFC counter reaches 0 → IDLE.
- Offers:
  - At most one *_req is high in any cycle.
  - A req stays high with stable sched_* outputs until its gnt.
  - A gnt is honoured only in a cycle where the matching req is high; any other gnt is ignored.
- ref_done = ref_gnt & ref_req.
- Reset:
  - State IDLE; all *_req, ref_done = 0; req_ready = 1.
  - All counters = 0; open_row, sched_* = 0.
  - Reset mid-operation discards the held request.

## Timing
- Command issued at grant cycle N. A counter is loaded at N with value T; the constraint is met at cycle N+T. A T of 0 is treated as 1.
- Gating:
  - rd_req / wr_req: tRCD met.
  - pre_req: tRAS, tRTP and tWTP all met.
  - act_req / ref_req: tRP (from PRE) and tRFC (from REF) met.
- A req is asserted combinationally in the first cycle its gating is met: earliest RD at N_act + t_rcd.
- Back-to-back column hits: the request is accepted at N+1 after a grant at N, so the next rd_req is possible at N+2.
- Counters saturate at 0. t_rtp and t_wtp share one counter, reloaded with the larger of the current residual and the new value.
- Request accepted in IDLE with no timing pending: act_req in the next cycle.

## Configuration
- BK_AUTO_PRE_EN defined — closed-page policy:
  - After a column grant, ACTIVE issues pre_req as soon as timing allows, unless a new held request hits open_row.
  - Any new request therefore normally needs an ACT.
- BK_AUTO_PRE_EN undefined — open-page policy: the row stays open until a row miss or ref_due.

## Test plan
- Read to closed bank, t_rcd=3, req ra=0x12 ca=0x40, all gnts immediate → act_req at N; rd_req first at N+3 with sched_ca=0x40; req_ready rises at N+4.
- Row hit then miss, open-page, t_ras=8, t_rtp=2, t_rp=3:
  - Hit on ra=0x12 → RD.
  - Then ra=0x13 → pre_req no earlier than max(ACT+8, RD+2); act_req for 0x13 at PRE+3.
- Scheduler stall on a held read: rd_gnt held low 5 cycles → rd_req and sched_ca/id/len stable all 5 cycles; no other *_req asserted.
- ref_due in ACTIVE with a held hit, t_rfc=20:
  - pre_req, then ref_req after tRP.
  - ref_done is a single pulse.
  - act_req no earlier than REF+20; the held request then completes.
- Reset asserted one cycle after act_gnt → next cycle all *_req = 0, req_ready = 1; the request is not replayed.
- BK_AUTO_PRE_EN build: single write, t_wtp=4 → pre_req at WR+4 (given tRAS met), bank returns to IDLE.
